imem_run_ctrl: RTL and testbench

//  Run controller and port arbiter for the single-port instruction ROM.

---
 rtl/imem_run_ctrl.sv | 113 +++++++++++
 tb/tb_imem_run_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_run_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : imem_run_ctrl                                                   |
// | Purpose  : Instruction-ROM port arbiter (UART programmer vs. CPU fetch)    |
// |            and CPU run-state sequencer (HALT / RUN / STEP / PROG).         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module imem_run_ctrl #(
  parameter int ROM_AW = 14,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              upg_rst_i,
  input  logic              upg_done_i,
  input  logic              upg_wen_i,
  input  logic [14:0]       upg_adr_i,
  input  logic [DATA_W-1:0] upg_dat_i,
  input  logic              enter_i,
  input  logic              step_mode_i,
  input  logic              halt_i,
  input  logic [ROM_AW-1:0] fetch_adr_i,
  output logic              rom_wea_o,
  output logic [ROM_AW-1:0] rom_addra_o,
  output logic [DATA_W-1:0] rom_dina_o,
  output logic              cpu_run_o,
  output logic              cpu_rst_o,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  prog_cnt_o
);

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_PROG = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_enter_q;
  logic             r_rst_pulse;
  logic             w_rst_pulse_nxt;
  logic [CNT_W-1:0] r_prog_cnt;

  logic w_prog_req;
  logic w_enter_rise;
  logic w_rom_wr;
  logic w_in_prog;

  assign w_prog_req   = ~upg_rst_i & ~upg_done_i;
  assign w_enter_rise = enter_i & ~r_enter_q;
  assign w_in_prog    = (r_state == S_PROG);
  // Bit 14 addresses data memory, so those writes are never ROM writes.
  assign w_rom_wr     = upg_wen_i & ~upg_adr_i[14];

  always_comb begin
    w_state_nxt     = r_state;
    w_rst_pulse_nxt = 1'b0;
    if (w_prog_req) begin
      w_state_nxt = S_PROG;
    end else begin
      case (r_state)
        S_PROG: begin
          w_state_nxt     = S_HALT;
          w_rst_pulse_nxt = 1'b1;
        end
        S_HALT: begin
          if (w_enter_rise) w_state_nxt = step_mode_i ? S_STEP : S_RUN;
        end
        S_STEP:  w_state_nxt = S_HALT;
        S_RUN: begin
          if (halt_i) w_state_nxt = S_HALT;
        end
        default: w_state_nxt = S_HALT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_HALT;
      r_enter_q   <= 1'b0;
      r_rst_pulse <= 1'b0;
      r_prog_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_enter_q   <= enter_i;
      r_rst_pulse <= w_rst_pulse_nxt;
      // Clearing on entry takes priority over any write in the same cycle.
      if (w_prog_req && !w_in_prog) begin
        r_prog_cnt <= '0;
      end else if (w_in_prog && w_rom_wr && (r_prog_cnt != C_CNT_MAX)) begin
        r_prog_cnt <= r_prog_cnt + C_CNT_ONE;
      end
    end
  end

  assign cpu_run_o   = (r_state == S_RUN) | (r_state == S_STEP);
  assign cpu_rst_o   = reset | w_in_prog | r_rst_pulse;
  assign state_o     = r_state;
  assign prog_cnt_o  = r_prog_cnt;

  assign rom_wea_o   = w_in_prog & w_rom_wr;
  assign rom_addra_o = w_in_prog ? upg_adr_i[ROM_AW-1:0] : fetch_adr_i;
  assign rom_dina_o  = w_in_prog ? upg_dat_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_imem_run_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_imem_run_ctrl                                                |
// | Purpose  : Self-checking bench: directed scenarios plus random stimulus    |
// |            compared every cycle against a behavioural model.               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_imem_run_ctrl;

  localparam int C_AW   = 14;
  localparam int C_DW   = 32;
  localparam int C_CW   = 3;
  localparam int C_MAX  = (1 << C_CW) - 1;
  localparam int C_HALT = 0;
  localparam int C_RUN  = 1;
  localparam int C_STEP = 2;
  localparam int C_PROG = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            upg_rst_i = 1'b1;
  logic            upg_done_i = 1'b0;
  logic            upg_wen_i = 1'b0;
  logic [14:0]     upg_adr_i = '0;
  logic [C_DW-1:0] upg_dat_i = '0;
  logic            enter_i = 1'b0;
  logic            step_mode_i = 1'b0;
  logic            halt_i = 1'b0;
  logic [C_AW-1:0] fetch_adr_i = 14'h0123;
  logic            rom_wea_o;
  logic [C_AW-1:0] rom_addra_o;
  logic [C_DW-1:0] rom_dina_o;
  logic            cpu_run_o;
  logic            cpu_rst_o;
  logic [1:0]      state_o;
  logic [C_CW-1:0] prog_cnt_o;

  imem_run_ctrl #(.ROM_AW(C_AW), .DATA_W(C_DW), .CNT_W(C_CW)) dut (
    .clk(clk), .reset(reset), .upg_rst_i(upg_rst_i), .upg_done_i(upg_done_i),
    .upg_wen_i(upg_wen_i), .upg_adr_i(upg_adr_i), .upg_dat_i(upg_dat_i),
    .enter_i(enter_i), .step_mode_i(step_mode_i), .halt_i(halt_i),
    .fetch_adr_i(fetch_adr_i), .rom_wea_o(rom_wea_o), .rom_addra_o(rom_addra_o),
    .rom_dina_o(rom_dina_o), .cpu_run_o(cpu_run_o), .cpu_rst_o(cpu_rst_o),
    .state_o(state_o), .prog_cnt_o(prog_cnt_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: run mode as an int, download word count as an int.
  int m_state = C_HALT;
  int m_cnt   = 0;
  bit m_enter_prev = 1'b0;
  bit m_after_prog = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state      <= C_HALT;
      m_cnt        <= 0;
      m_enter_prev <= 1'b0;
      m_after_prog <= 1'b0;
    end else begin
      bit req, rise, wr;
      req  = !upg_rst_i && !upg_done_i;
      rise = enter_i && !m_enter_prev;
      wr   = upg_wen_i && !upg_adr_i[14];
      m_enter_prev <= enter_i;
      m_after_prog <= (m_state == C_PROG) && !req;
      if (req && m_state != C_PROG) m_cnt <= 0;
      else if (m_state == C_PROG && wr) m_cnt <= (m_cnt < C_MAX) ? m_cnt + 1 : C_MAX;
      if (req)                              m_state <= C_PROG;
      else if (m_state == C_PROG)           m_state <= C_HALT;
      else if (m_state == C_HALT && rise)   m_state <= step_mode_i ? C_STEP : C_RUN;
      else if (m_state == C_STEP)           m_state <= C_HALT;
      else if (m_state == C_RUN && halt_i)  m_state <= C_HALT;
    end
  end

  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      bit prog;
      prog = (m_state == C_PROG);
      chk("state", 32'(state_o), 32'(m_state));
      chk("prog_cnt", 32'(prog_cnt_o), 32'(m_cnt));
      chk("cpu_run", 32'(cpu_run_o), 32'(m_state == C_RUN || m_state == C_STEP));
      chk("cpu_rst", 32'(cpu_rst_o), 32'(reset || prog || m_after_prog));
      chk("rom_wea", 32'(rom_wea_o), 32'(prog && upg_wen_i && !upg_adr_i[14]));
      chk("rom_addra", 32'(rom_addra_o), prog ? 32'(upg_adr_i[13:0]) : 32'(fetch_adr_i));
      chk("rom_dina", rom_dina_o, prog ? upg_dat_i : 32'h0);
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  int wea_seen;
  int run_seen;
  int prog_left;

  initial begin
    // T1 reset
    chk_en = 1'b1;
    tick(); tick();
    chk("rst_cpu_rst_during", 32'(cpu_rst_o), 32'd1);
    chk("rst_cpu_run_during", 32'(cpu_run_o), 32'd0);
    reset = 1'b0;
    tick();
    chk("t1_state", 32'(state_o), 32'd0);
    chk("t1_cpu_rst", 32'(cpu_rst_o), 32'd0);
    chk("t1_cnt", 32'(prog_cnt_o), 32'd0);
    chk("t1_addr", 32'(rom_addra_o), 32'h0123);

    // T2 download
    upg_rst_i = 1'b0;
    tick();
    chk("t2_prog", 32'(state_o), 32'd3);
    wea_seen = 0;
    for (int i = 0; i < 6; i++) begin
      upg_wen_i = 1'b1;
      upg_adr_i = (i == 5) ? 15'h4000 : 15'(i);
      upg_dat_i = $urandom;
      #1 wea_seen += int'(rom_wea_o);
      tick();
    end
    upg_wen_i  = 1'b0;
    upg_done_i = 1'b1;
    tick();
    chk("t2_wea_pulses", 32'(wea_seen), 32'd5);
    chk("t2_cnt", 32'(prog_cnt_o), 32'd5);
    chk("t2_halt", 32'(state_o), 32'd0);
    chk("t2_rst_pulse", 32'(cpu_rst_o), 32'd1);
    upg_rst_i = 1'b1; upg_done_i = 1'b0;
    tick();
    chk("t2_rst_end", 32'(cpu_rst_o), 32'd0);

    // T3 run
    step_mode_i = 1'b0; enter_i = 1'b1;
    tick();
    chk("t3_run", 32'(state_o), 32'd1);
    tick(); tick();
    enter_i = 1'b0;
    tick();
    chk("t3_run_held", 32'(cpu_run_o), 32'd1);
    halt_i = 1'b1;
    tick();
    chk("t3_halted", 32'(state_o), 32'd0);
    halt_i = 1'b0;

    // T4 step
    step_mode_i = 1'b1;
    run_seen = 0;
    for (int k = 0; k < 4; k++) begin
      enter_i = 1'b1; tick(); run_seen += int'(cpu_run_o);
      enter_i = 1'b0; tick(); run_seen += int'(cpu_run_o);
      tick(); run_seen += int'(cpu_run_o);
    end
    chk("t4_step_cycles", 32'(run_seen), 32'd4);
    chk("t4_state", 32'(state_o), 32'd0);

    // T5 preempt
    step_mode_i = 1'b0; enter_i = 1'b1;
    tick();
    enter_i = 1'b0; upg_rst_i = 1'b0; upg_adr_i = 15'h0055; fetch_adr_i = 14'h0777;
    tick();
    chk("t5_prog", 32'(state_o), 32'd3);
    chk("t5_run_off", 32'(cpu_run_o), 32'd0);
    chk("t5_mux", 32'(rom_addra_o), 32'h0055);
    upg_rst_i = 1'b1;
    tick(); tick();

    // T6 stray write
    upg_wen_i = 1'b1; upg_adr_i = 15'h0010;
    #1 chk("t6_wea", 32'(rom_wea_o), 32'd0);
    tick();
    upg_wen_i = 1'b0;
    chk("t6_cnt", 32'(prog_cnt_o), 32'd0);

    // Random phase
    prog_left = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 199) == 0) reset = 1'b1;
      if (prog_left > 0) prog_left--;
      else if ($urandom_range(0, 39) == 0) prog_left = $urandom_range(2, 25);
      upg_rst_i   = (prog_left == 0);
      upg_done_i  = ($urandom_range(0, 11) == 0);
      upg_wen_i   = $urandom_range(0, 1) == 1;
      upg_adr_i   = {($urandom_range(0, 7) == 0), 14'($urandom)};
      upg_dat_i   = $urandom;
      enter_i     = ($urandom_range(0, 3) == 0);
      halt_i      = ($urandom_range(0, 7) == 0);
      fetch_adr_i = 14'($urandom);
      if ($urandom_range(0, 15) == 0) step_mode_i = ~step_mode_i;
    end
    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
